// File: rtl/bcd2421_seq_ctrl.sv
// bcd2421_seq_ctrl
//   Sequencing controller for 8421 -> 2421 BCD conversion. It accepts a packed
//   multi-digit 8421 word on a valid/ready handshake. One shared 4-bit
//   converter processes the digits, one per cycle, least-significant digit
//   first. The 2421 word and a per-digit illegal-digit mask are then held on
//   an output valid/ready handshake until the consumer takes them.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      producer presents a word on in_bcd
//   in_ready      controller can accept a word (IDLE)
//   in_bcd        packed 8421 digits, digit i = [4i+3:4i]
//   out_valid     result word available (DONE)
//   out_ready     consumer accepts the result
//   out_code      packed 2421 digits, same order as in_bcd
//   out_err       OR of out_err_mask
//   out_err_mask  bit i set when input digit i was 10..15
//
// State | Meaning
// IDLE  | waiting for an input word, in_ready=1
// CONV  | converting digit r_idx, one digit per cycle
// DONE  | result held, out_valid=1 until out_ready

module bcd2421_digit (
  input  logic [3:0] i_bcd,
  output logic [3:0] o_code,
  output logic       o_err
);
  always_comb begin
    o_code = 4'b0000;
    o_err  = 1'b0;
    case (i_bcd)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4: o_code = i_bcd;
      4'd5:    o_code = 4'b1011;
      4'd6:    o_code = 4'b1100;
      4'd7:    o_code = 4'b1101;
      4'd8:    o_code = 4'b1110;
      4'd9:    o_code = 4'b1111;
      default: o_err  = 1'b1;   // 10..15: code forced to 0000
    endcase
  end
endmodule

module bcd2421_seq_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_code,
  output logic                  out_err,
  output logic [DIGITS-1:0]     out_err_mask
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [4*DIGITS-1:0]   r_in;
  logic [IDX_W-1:0]      r_idx;
  logic [4*DIGITS-1:0]   r_code;
  logic [DIGITS-1:0]     r_mask;
  logic [3:0]            w_digit;
  logic [3:0]            w_conv;
  logic                  w_conv_err;
  logic                  w_last;

  assign w_last = (r_idx == IDX_W'(DIGITS - 1));

  // Digit select written as a compare-mux so no index can run past the word
  // even when r_idx has spare codes (non-power-of-two DIGITS).
  always_comb begin
    w_digit = 4'b0000;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) w_digit = r_in[4*i +: 4];
    end
  end

  bcd2421_digit u_digit (
    .i_bcd  (w_digit),
    .o_code (w_conv),
    .o_err  (w_conv_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = CONV;
      end
      CONV: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in   <= '0;
      r_idx  <= '0;
      r_code <= '0;
      r_mask <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_in   <= in_bcd;
            r_idx  <= '0;
            r_code <= '0;
            r_mask <= '0;
          end
        end
        CONV: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
              r_code[4*i +: 4] <= w_conv;
              r_mask[i]        <= w_conv_err;
            end
          end
          r_idx <= r_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_code     = r_code;
  assign out_err_mask = r_mask;
  assign out_err      = |r_mask;

endmodule

// File: tb/tb_bcd2421_seq_ctrl.sv
// Directed bench for bcd2421_seq_ctrl with DIGITS=4.
module tb_bcd2421_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bcd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_code;
  logic        out_err;
  logic [3:0]  out_err_mask;

  int n_cmp;
  int n_bad;

  bcd2421_seq_ctrl #(.DIGITS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_bcd       (in_bcd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_code     (out_code),
    .out_err      (out_err),
    .out_err_mask (out_err_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One word through the controller with out_ready high. Sampling is 1 time
  // unit after each rising edge; in_bcd is scrambled after the accept edge.
  task automatic do_word(input string tag, input logic [15:0] bcd,
                         input logic [15:0] exp_code, input logic [3:0] exp_mask);
    int cnt;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_bcd    = bcd;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_bcd   = ~bcd;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_latency"},  64'(cnt), 64'd4);
    chk({tag, "_code"},     64'(out_code), 64'(exp_code));
    chk({tag, "_mask"},     64'(out_err_mask), 64'(exp_mask));
    chk({tag, "_err"},      64'(out_err), 64'(|exp_mask));
    chk({tag, "_busy"},     64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_valid_1cy"}, 64'(out_valid), 64'd0);
    chk({tag, "_idle"},      64'(in_ready), 64'd1);
  endtask

  logic [15:0] res [4];
  int          acc_t [4];
  int          acc_n;
  int          res_n;
  int          cnt;

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bcd    = '0;
    out_ready = 1'b0;

    #12;
    chk("rst_in_ready",  64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_code",      64'(out_code), 64'd0);
    chk("rst_err",       64'(out_err), 64'd0);
    chk("rst_mask",      64'(out_err_mask), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // accept a word, then async reset two cycles into CONV (mid-cycle)
    in_valid = 1'b1;
    in_bcd   = 16'h9876;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("conv_busy", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_code",      64'(out_code), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_word("w9876", 16'h9876, 16'hFEDC, 4'b0000);
    do_word("w4321", 16'h4321, 16'h4321, 4'b0000);
    do_word("w0505", 16'h0505, 16'h0B0B, 4'b0000);
    do_word("wA3F5", 16'hA3F5, 16'h030B, 4'b1010);

    // back-pressure: hold out_ready low for 10 cycles once the result is up
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bcd    = 16'h5555;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("bp_latency", 64'(cnt), 64'd4);
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_code",  64'(out_code), 64'h0000_0000_0000_BBBB);
      chk("bp_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_idle",  64'(in_ready), 64'd1);
    chk("bp_rel_valid", 64'(out_valid), 64'd0);

    // in_valid held high across two words
    acc_n    = 0;
    res_n    = 0;
    in_valid = 1'b1;
    in_bcd   = 16'h0001;
    for (int c = 0; c < 40 && res_n < 2; c++) begin
      if (in_ready && acc_n < 4) begin
        acc_t[acc_n] = c;
        acc_n++;
      end
      if (out_valid && res_n < 4) begin
        res[res_n] = out_code;
        res_n++;
      end
      @(posedge clk); #1;
      if (acc_n == 1) in_bcd = 16'h0009;
    end
    in_valid = 1'b0;
    chk("b2b_accepts", 64'(acc_n), 64'd2);
    chk("b2b_results", 64'(res_n), 64'd2);
    if (acc_n >= 2) chk("b2b_spacing", 64'(acc_t[1] - acc_t[0]), 64'd6);
    if (res_n >= 1) chk("b2b_res0", 64'(res[0]), 64'h0001);
    if (res_n >= 2) chk("b2b_res1", 64'(res[1]), 64'h000F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
